// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder and the fetch unit.
package imem_responder_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned IMEM_BYTES  = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_store_1r1w.sv
// Word array with one synchronous read port and one write port; a same-edge
// write to the read index is forwarded into the read register.
module imem_store_1r1w
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts byte-addressed requests and returns the
// stored word after WAIT_CYCLES wait states, one request outstanding at a time.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = IMEM_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DATA_W      = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  imem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mis_q, mis_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept, load, load_mis, rd_en;
  logic [ADDR_W-1:0] req_idx, rd_idx;
  logic              req_mis;
  logic [DATA_W-1:0] rd_data;
  logic              unused_req_hi;

  // Upper address bits are dropped so fetches wrap within the store.
  assign req_idx       = req_addr[ADDR_W+1:2];
  assign req_mis       = |req_addr[1:0];
  assign unused_req_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    mis_d     = mis_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      WAIT: begin
        if (cnt_q == 4'd0) begin
          load    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = req_valid && req_ready;
    if (accept) begin
      idx_d   = req_idx;
      mis_d   = req_mis;
      cnt_d   = CNT_LOAD;
      state_d = ZERO_WAIT ? RESP : WAIT;
      if (ZERO_WAIT) load = 1'b1;
    end

    // With no wait states the read uses the live request, not the latched one.
    load_mis  = (ZERO_WAIT && accept) ? req_mis : mis_q;
    rd_idx    = (ZERO_WAIT && accept) ? req_idx : idx_q;
    rd_en     = load && !load_mis;
    rsp_err_d = load ? load_mis : rsp_err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      mis_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mis_q     <= mis_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  imem_store_1r1w #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_store (
    .clk_i  (clk),
    .rst_ni (rst),
    .we_i   (ld_en),
    .waddr_i(ld_addr),
    .wdata_i(ld_data),
    .re_i   (rd_en),
    .raddr_i(rd_idx),
    .rdata_o(rd_data)
  );

  // A misaligned response keeps the store's read register untouched and masks it.
  assign rsp_data = rsp_err_q ? '0 : rd_data;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != IDLE);

endmodule
